fp_add_seq: RTL

FP_ADD_SEQ -- requirements
Module: fp_add_seq

---
 rtl/fp_add_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fp_add_seq.sv
// rtl/fp_add_seq.sv - multi-cycle single-precision adder, truncating, denormals flushed to zero
module fp_add_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic        under_overflow,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state;
    logic        sign_a;
    logic        sign_b;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic [7:0]  diff;
    logic [24:0] sum;
    logic        res_sign;
    logic [7:0]  res_exp;

    logic [7:0]  exp_a_in;
    logic [7:0]  exp_b_in;
    logic [23:0] man_a_in;
    logic [23:0] man_b_in;
    logic        inf_a;
    logic        inf_b;
    logic        swap;

    always_comb begin
        exp_a_in = a[30:23];
        exp_b_in = b[30:23];
        man_a_in = (exp_a_in != 8'd0) ? {1'b1, a[22:0]} : 24'h0;
        man_b_in = (exp_b_in != 8'd0) ? {1'b1, b[22:0]} : 24'h0;
        inf_a    = (exp_a_in == 8'hFF);
        inf_b    = (exp_b_in == 8'hFF);
        swap     = (exp_b_in > exp_a_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            man_a          <= 24'h0;
            man_b          <= 24'h0;
            diff           <= 8'h0;
            sum            <= 25'h0;
            res_sign       <= 1'b0;
            res_exp        <= 8'h0;
            result         <= 32'h0;
            under_overflow <= 1'b0;
            out_valid      <= 1'b0;
            in_ready       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (inf_a || inf_b) begin
                            state          <= DONE;
                            out_valid      <= 1'b1;
                            under_overflow <= 1'b1;
                            if (inf_a && inf_b && (a[31] != b[31]))
                                result <= 32'h7FC00000;
                            else if (inf_a)
                                result <= {a[31], 8'hFF, 23'h0};
                            else
                                result <= {b[31], 8'hFF, 23'h0};
                        end else begin
                            state <= ALIGN;
                            // Operand A always carries the larger exponent from here on.
                            if (swap) begin
                                sign_a  <= b[31];
                                sign_b  <= a[31];
                                man_a   <= man_b_in;
                                man_b   <= man_a_in;
                                res_exp <= exp_b_in;
                                diff    <= exp_b_in - exp_a_in;
                            end else begin
                                sign_a  <= a[31];
                                sign_b  <= b[31];
                                man_a   <= man_a_in;
                                man_b   <= man_b_in;
                                res_exp <= exp_a_in;
                                diff    <= exp_a_in - exp_b_in;
                            end
                        end
                    end
                end

                ALIGN: begin
                    if (diff >= 8'd24) begin
                        man_b <= 24'h0;
                        diff  <= 8'h0;
                        state <= ADD;
                    end else if (diff == 8'd0) begin
                        state <= ADD;
                    end else begin
                        man_b <= man_b >> 1;
                        diff  <= diff - 8'd1;
                        if (diff == 8'd1)
                            state <= ADD;
                    end
                end

                ADD: begin
                    state <= NORM;
                    if (sign_a == sign_b) begin
                        sum      <= {1'b0, man_a} + {1'b0, man_b};
                        res_sign <= sign_a;
                    end else if (man_a > man_b) begin
                        sum      <= {1'b0, man_a} - {1'b0, man_b};
                        res_sign <= sign_a;
                    end else if (man_b > man_a) begin
                        sum      <= {1'b0, man_b} - {1'b0, man_a};
                        res_sign <= sign_b;
                    end else begin
                        sum      <= 25'h0;
                        res_sign <= 1'b0;
                    end
                end

                NORM: begin
                    if (sum == 25'h0) begin
                        result         <= 32'h0;
                        under_overflow <= 1'b0;
                        out_valid      <= 1'b1;
                        state          <= DONE;
                    end else if (sum[24]) begin
                        if (res_exp == 8'd254) begin
                            result         <= {res_sign, 8'hFF, 23'h0};
                            under_overflow <= 1'b1;
                        end else begin
                            result         <= {res_sign, res_exp + 8'd1, sum[23:1]};
                            under_overflow <= 1'b0;
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (sum[23]) begin
                        result         <= {res_sign, res_exp, sum[22:0]};
                        under_overflow <= 1'b0;
                        out_valid      <= 1'b1;
                        state          <= DONE;
                    end else if (res_exp <= 8'd1) begin
                        // A further left shift would need exponent 0, which is flushed.
                        result         <= {res_sign, 31'h0};
                        under_overflow <= 1'b1;
                        out_valid      <= 1'b1;
                        state          <= DONE;
                    end else begin
                        sum     <= sum << 1;
                        res_exp <= res_exp - 8'd1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
